// File: rtl/microsequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : microsequencer
// Purpose  : Two-state (FETCH/EXEC) microprogram sequencer. In FETCH the
//            microinstruction at MPC is loaded into MIR; in EXEC the MIR
//            control fields drive the datapath and the next MPC is formed
//            from NEXT_ADDRESS, the JAMN/JAMZ flag jams and the JMPC dispatch.
// Ports    : clk, reset_n (async, active-low)
//            cs_addr  [8:0]  out  control-store address (= MPC)
//            cs_data  [35:0] in   microinstruction from asynchronous ROM
//            alu_n, alu_z    in   live ALU flags
//            mbr      [7:0]  in   MBR byte for JMPC dispatch
//            stall           in   memory wait (honoured only with macro)
//            a_sel [3:0], alu_ctrl [7:0], c_en [8:0], mem_ctrl [2:0], exec
// Config   : MICROSEQ_STALL_EN - when defined, stall=1 at an EXEC edge
//            holds the sequencer in EXEC with all state and outputs frozen.
// Revision : 1.0 - initial release
// ============================================================================
module microsequencer (
    input  logic        clk,
    input  logic        reset_n,
    output logic [8:0]  cs_addr,
    input  logic [35:0] cs_data,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic [7:0]  mbr,
    input  logic        stall,
    output logic [3:0]  a_sel,
    output logic [7:0]  alu_ctrl,
    output logic [8:0]  c_en,
    output logic [2:0]  mem_ctrl,
    output logic        exec
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    // A-bus select value that enables no driver
    localparam logic [3:0] A_SEL_IDLE = 4'hF;

    state_t      state_q, state_d;
    logic [8:0]  mpc_q, mpc_d;
    logic [35:0] mir_q, mir_d;
    logic        n_q, n_d;
    logic        z_q, z_d;
    logic [3:0]  a_sel_q, a_sel_d;
    logic [7:0]  alu_ctrl_q, alu_ctrl_d;
    logic [8:0]  c_en_q, c_en_d;
    logic [2:0]  mem_ctrl_q, mem_ctrl_d;
    logic        exec_q, exec_d;

    logic        hold;
    logic [8:0]  next_addr;

`ifdef MICROSEQ_STALL_EN
    assign hold = stall;
`else
    // Port kept for pin compatibility; forced inactive in this build.
    assign hold = stall & 1'b0;
`endif

    // Pure OR merge, never an add: bit 8 takes the flag jams, bits 7:0 the
    // MBR dispatch, so the result can reach 0x1FF but never wraps.
    assign next_addr = {mir_q[35] | (mir_q[25] & alu_n) | (mir_q[24] & alu_z),
                        mir_q[34:27] | (mbr & {8{mir_q[26]}})};

    always_comb begin
        state_d    = state_q;
        mpc_d      = mpc_q;
        mir_d      = mir_q;
        n_d        = n_q;
        z_d        = z_q;
        a_sel_d    = a_sel_q;
        alu_ctrl_d = alu_ctrl_q;
        c_en_d     = c_en_q;
        mem_ctrl_d = mem_ctrl_q;
        exec_d     = exec_q;
        case (state_q)
            ST_FETCH: begin
                // Outputs are loaded from cs_data alongside MIR so that they
                // come straight out of flops for the whole EXEC cycle.
                mir_d      = cs_data;
                state_d    = ST_EXEC;
                a_sel_d    = cs_data[3:0];
                alu_ctrl_d = cs_data[23:16];
                c_en_d     = cs_data[15:7];
                mem_ctrl_d = cs_data[6:4];
                exec_d     = 1'b1;
            end
            ST_EXEC: begin
                if (!hold) begin
                    n_d        = alu_n;
                    z_d        = alu_z;
                    mpc_d      = next_addr;
                    state_d    = ST_FETCH;
                    a_sel_d    = A_SEL_IDLE;
                    alu_ctrl_d = 8'h00;
                    c_en_d     = 9'h000;
                    mem_ctrl_d = 3'b000;
                    exec_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            mpc_q      <= 9'h000;
            mir_q      <= 36'h0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            a_sel_q    <= A_SEL_IDLE;
            alu_ctrl_q <= 8'h00;
            c_en_q     <= 9'h000;
            mem_ctrl_q <= 3'b000;
            exec_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mpc_q      <= mpc_d;
            mir_q      <= mir_d;
            n_q        <= n_d;
            z_q        <= z_d;
            a_sel_q    <= a_sel_d;
            alu_ctrl_q <= alu_ctrl_d;
            c_en_q     <= c_en_d;
            mem_ctrl_q <= mem_ctrl_d;
            exec_q     <= exec_d;
        end
    end

    assign cs_addr  = mpc_q;
    assign a_sel    = a_sel_q;
    assign alu_ctrl = alu_ctrl_q;
    assign c_en     = c_en_q;
    assign mem_ctrl = mem_ctrl_q;
    assign exec     = exec_q;

endmodule
`default_nettype wire

// File: tb/tb_microsequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_microsequencer
// Purpose  : Self-checking bench for microsequencer. A behavioural ROM and a
//            next-address model built from the MIR field rules supply every
//            expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microsequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  cs_addr;
    logic [35:0] cs_data;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic [7:0]  mbr = 8'h00;
    logic        stall = 1'b0;
    logic [3:0]  a_sel;
    logic [7:0]  alu_ctrl;
    logic [8:0]  c_en;
    logic [2:0]  mem_ctrl;
    logic        exec;

    logic [35:0] rom [0:511];
    int checks = 0;
    int errors = 0;

    assign cs_data = rom[cs_addr];

    microsequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cs_addr  (cs_addr),
        .cs_data  (cs_data),
        .alu_n    (alu_n),
        .alu_z    (alu_z),
        .mbr      (mbr),
        .stall    (stall),
        .a_sel    (a_sel),
        .alu_ctrl (alu_ctrl),
        .c_en     (c_en),
        .mem_ctrl (mem_ctrl),
        .exec     (exec)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] mk(input logic [8:0] nxt, input logic jmpc,
                                       input logic jamn, input logic jamz,
                                       input logic [7:0] alu, input logic [8:0] c,
                                       input logic [2:0] mem, input logic [3:0] a);
        return {nxt, jmpc, jamn, jamz, alu, c, mem, a};
    endfunction

    // Next address from the field rules: OR in MBR on JMPC, set 0x100 on a jam.
    function automatic logic [8:0] model_next(input logic [35:0] w, input logic n,
                                              input logic z, input logic [7:0] m);
        int addr;
        addr = int'(w[35:27]);
        if (w[26]) addr = addr | int'(m);
        if ((w[25] && n) || (w[24] && z)) addr = addr | 256;
        return addr[8:0];
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        stall = 1'b0;
        alu_n = 1'b0;
        alu_z = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rom[0] = mk(9'h1AB, 1'b1, 1'b1, 1'b1, 8'hFF, 9'h1FF, 3'b111, 4'h0);
            stall = 1'b1;
            step();
            checks++;
            if ({cs_addr, a_sel, alu_ctrl, c_en, mem_ctrl, exec} !==
                {9'h000, 4'hF, 8'h00, 9'h000, 3'b000, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle: got addr=%h a=%h alu=%h c=%h mem=%b exec=%b, want addr=000 a=f alu=00 c=000 mem=000 exec=0",
                         cs_addr, a_sel, alu_ctrl, c_en, mem_ctrl, exec);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_basic();
        rom[0] = mk(9'h005, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 3'b000, 4'h2);
        apply_reset();
        checks++;
        if (cs_addr !== 9'h000 || exec !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_addr: got addr=%h exec=%b, want addr=000 exec=0", cs_addr, exec);
        end
        step();
        checks++;
        if (exec !== 1'b1 || a_sel !== 4'h2) begin
            errors++;
            $display("FAIL basic_exec_asel: got exec=%b a=%h, want exec=1 a=2", exec, a_sel);
        end
        step();
        checks++;
        if (cs_addr !== 9'h005 || exec !== 1'b0 || a_sel !== 4'hF) begin
            errors++;
            $display("FAIL basic_next_addr: got addr=%h exec=%b a=%h, want addr=005 exec=0 a=f", cs_addr, exec, a_sel);
        end
    endtask

    task automatic test_jamz();
        logic       zs [2]  = '{1'b1, 1'b0};
        logic [8:0] exp [2] = '{9'h110, 9'h010};
        for (int i = 0; i < 2; i++) begin
            rom[0] = mk(9'h010, 1'b0, 1'b0, 1'b1, 8'h00, 9'h000, 3'b000, 4'h0);
            apply_reset();
            step();
            alu_z = zs[i];
            alu_n = 1'b1;   // JAMN clear, so N must not matter
            step();
            checks++;
            if (cs_addr !== exp[i]) begin
                errors++;
                $display("FAIL jamz_case%0d: got addr=%h, want %h", i, cs_addr, exp[i]);
            end
        end
    endtask

    task automatic test_jmpc();
        logic [35:0] w  [2] = '{36'h0, 36'h0};
        logic [7:0]  m  [2] = '{8'h60, 8'hFF};
        logic [8:0]  exp[2] = '{9'h060, 9'h1FF};
        w[0] = mk(9'h000, 1'b1, 1'b0, 1'b0, 8'h00, 9'h000, 3'b000, 4'h0);
        w[1] = mk(9'h100, 1'b1, 1'b1, 1'b0, 8'h00, 9'h000, 3'b000, 4'h0);
        for (int i = 0; i < 2; i++) begin
            rom[0] = w[i];
            apply_reset();
            step();
            mbr = m[i];
            alu_n = (i == 1);
            alu_z = 1'b0;
            step();
            checks++;
            if (cs_addr !== exp[i]) begin
                errors++;
                $display("FAIL jmpc_case%0d: got addr=%h, want %h", i, cs_addr, exp[i]);
            end
        end
        mbr = 8'h00;
    endtask

    task automatic test_stall();
        rom[0] = mk(9'h007, 1'b0, 1'b0, 1'b0, 8'h3C, 9'h0AA, 3'b010, 4'h1);
        apply_reset();
        stall = 1'b1;   // must not delay FETCH
        step();
        checks++;
        if (exec !== 1'b1 || mem_ctrl !== 3'b010) begin
            errors++;
            $display("FAIL stall_fetch_ignored: got exec=%b mem=%b, want exec=1 mem=010", exec, mem_ctrl);
        end
`ifdef MICROSEQ_STALL_EN
        for (int i = 0; i < 3; i++) begin
            alu_z = 1'b1;
            step();
            checks++;
            if ({exec, mem_ctrl, a_sel, alu_ctrl, c_en, cs_addr} !==
                {1'b1, 3'b010, 4'h1, 8'h3C, 9'h0AA, 9'h000}) begin
                errors++;
                $display("FAIL stall_hold%0d: got exec=%b mem=%b a=%h alu=%h c=%h addr=%h, want exec=1 mem=010 a=1 alu=3c c=0aa addr=000",
                         i, exec, mem_ctrl, a_sel, alu_ctrl, c_en, cs_addr);
            end
        end
        stall = 1'b0;
        step();
`else
        step();
        stall = 1'b0;
`endif
        checks++;
        if (cs_addr !== 9'h007 || exec !== 1'b0 || mem_ctrl !== 3'b000) begin
            errors++;
            $display("FAIL stall_release: got addr=%h exec=%b mem=%b, want addr=007 exec=0 mem=000", cs_addr, exec, mem_ctrl);
        end
    endtask

    task automatic test_reset_mid_exec();
        rom[0]     = mk(9'h033, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 3'b000, 4'h0);
        rom[9'h33] = mk(9'h044, 1'b0, 1'b0, 1'b0, 8'h11, 9'h1FF, 3'b111, 4'h4);
        apply_reset();
        step();
        step();
        step();
        checks++;
        if (exec !== 1'b1 || c_en !== 9'h1FF || cs_addr !== 9'h033) begin
            errors++;
            $display("FAIL midexec_setup: got exec=%b c=%h addr=%h, want exec=1 c=1ff addr=033", exec, c_en, cs_addr);
        end
        #2;
        reset_n = 1'b0;
        #1;             // still before the next clock edge
        checks++;
        if ({c_en, mem_ctrl, exec, a_sel, cs_addr} !== {9'h000, 3'b000, 1'b0, 4'hF, 9'h000}) begin
            errors++;
            $display("FAIL midexec_async_abort: got c=%h mem=%b exec=%b a=%h addr=%h, want c=000 mem=000 exec=0 a=f addr=000",
                     c_en, mem_ctrl, exec, a_sel, cs_addr);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (cs_addr !== 9'h000 || exec !== 1'b1 || a_sel !== rom[0][3:0]) begin
            errors++;
            $display("FAIL midexec_restart: got addr=%h exec=%b a=%h, want addr=000 exec=1 a=%h", cs_addr, exec, a_sel, rom[0][3:0]);
        end
    endtask

    task automatic test_random();
        logic [63:0] tmp;
        logic [35:0] w;
        logic [8:0]  exp_mpc;
        int          nstall;
        bit          holding;
        for (int i = 0; i < 512; i++) begin
            tmp = {$urandom(), $urandom()};
            rom[i] = tmp[35:0];
        end
        apply_reset();
        exp_mpc = 9'h000;
        for (int k = 0; k < 1000; k++) begin
            checks++;
            if ({cs_addr, a_sel, alu_ctrl, c_en, mem_ctrl, exec} !==
                {exp_mpc, 4'hF, 8'h00, 9'h000, 3'b000, 1'b0}) begin
                errors++;
                $display("FAIL rand_fetch%0d: got addr=%h a=%h alu=%h c=%h mem=%b exec=%b, want addr=%h a=f alu=00 c=000 mem=000 exec=0",
                         k, cs_addr, a_sel, alu_ctrl, c_en, mem_ctrl, exec, exp_mpc);
            end
            w = rom[exp_mpc];
            stall = $urandom_range(0, 1) != 0;
            mbr = 8'($urandom_range(0, 255));
            step();
            nstall = 0;
            holding = 1'b1;
            while (holding) begin
                checks++;
                if ({exec, a_sel, alu_ctrl, c_en, mem_ctrl, cs_addr} !==
                    {1'b1, w[3:0], w[23:16], w[15:7], w[6:4], exp_mpc}) begin
                    errors++;
                    $display("FAIL rand_exec%0d: got exec=%b a=%h alu=%h c=%h mem=%b addr=%h, want exec=1 a=%h alu=%h c=%h mem=%b addr=%h",
                             k, exec, a_sel, alu_ctrl, c_en, mem_ctrl, cs_addr,
                             w[3:0], w[23:16], w[15:7], w[6:4], exp_mpc);
                end
                alu_n = $urandom_range(0, 1) != 0;
                alu_z = $urandom_range(0, 1) != 0;
                mbr = 8'($urandom_range(0, 255));
                stall = (nstall < 3) && ($urandom_range(0, 2) == 0);
                step();
`ifdef MICROSEQ_STALL_EN
                if (stall) begin
                    nstall++;
                end else begin
                    exp_mpc = model_next(w, alu_n, alu_z, mbr);
                    holding = 1'b0;
                end
`else
                exp_mpc = model_next(w, alu_n, alu_z, mbr);
                holding = 1'b0;
`endif
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 36'h0;
        test_reset();
        test_basic();
        test_jamz();
        test_jmpc();
        test_stall();
        test_reset_mid_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 cs_addr  out  9  control-store address; combinational copy of MPC.
REQ-004 cs_data  in  36  microinstruction read from control store, valid in the same cycle as cs_addr (asynchronous ROM).
REQ-005 alu_n, alu_z  in  1 each  ALU negative/zero flags from the current datapath cycle.
REQ-006 mbr  in  8  MBR contents, used for JMPC dispatch.
REQ-007 stall  in  1  memory-wait request; used only when MICROSEQ_STALL_EN is defined.
REQ-008 a_sel  out  4  A-bus source select to the A-bus decoder.
REQ-009 alu_ctrl  out  8  ALU/shifter control field.
REQ-010 c_en  out  9  C-bus register write enables.
REQ-011 mem_ctrl  out  3  {WRITE, READ, FETCH} memory strobes.
REQ-012 exec  out  1  high while the microsequencer is in the EXEC state.

Function
REQ-013 MIR field map SHALL be NEXT_ADDRESS[35:27], JMPC[26], JAMN[25], JAMZ[24], ALU[23:16], C[15:7], MEM[6:4], A[3:0].
REQ-014 The block SHALL be a two-state FSM: FETCH and EXEC.
REQ-015 FETCH: MIR SHALL load cs_data at the clock edge, and the state SHALL move to EXEC.
REQ-016 EXEC: the outputs SHALL drive MIR fields (a_sel=MIR[3:0], alu_ctrl=MIR[23:16], c_en=MIR[15:7], mem_ctrl=MIR[6:4]).
REQ-017 EXEC end edge: the N and Z registers SHALL latch alu_n and alu_z, MPC SHALL load the next address, and the state SHALL return to FETCH.
REQ-018 In FETCH the block SHALL drive idle outputs: a_sel=4'hF (no A-bus driver enabled), alu_ctrl=0, c_en=0, mem_ctrl=0, exec=0.
REQ-019 Next address bits [7:0] SHALL equal NEXT_ADDRESS[7:0], ORed with mbr when JMPC=1.
REQ-020 Next address bit [8] SHALL equal NEXT_ADDRESS[8] | (JAMN & alu_n) | (JAMZ & alu_z), using the live flags at the EXEC end edge.
REQ-021 Address computation SHALL be 9-bit with no carry; OR-merging never wraps, and address 0x1FF is legal.
REQ-022 The latency SHALL be one microinstruction per 2 clocks when no stall is applied.
REQ-023 The N and Z registers SHALL hold their value outside EXEC end edges; they exist only for observation and are not used for branching.

Reset
REQ-024 While reset_n=0: MPC=0, MIR=0, N=Z=0, state=FETCH, and all outputs SHALL be at their idle values (REQ-018).
REQ-025 Reset asserted in EXEC SHALL abort the microinstruction immediately; no c_en or mem_ctrl pulse SHALL complete.
REQ-026 After reset_n rises, the first FETCH SHALL read address 0x000.

Configuration
REQ-027 Macro MICROSEQ_STALL_EN: when defined, stall=1 sampled at an EXEC edge SHALL keep the state in EXEC, hold MPC, MIR, N and Z, and hold all outputs stable; the FSM advances on the first EXEC edge with stall=0.
REQ-028 Without MICROSEQ_STALL_EN, the stall port SHALL remain present but be ignored; the timing is exactly per REQ-022.
REQ-029 Stall SHALL have no effect in FETCH in either build.

Verification
REQ-030 Reset, release, ROM[0]=NEXT 0x005, A=4'h2: the first cs_addr is 0x000; the EXEC cycle shows a_sel=2; the following cs_addr is 0x005.
REQ-031 JAMZ=1, NEXT=0x010, alu_z=1 at the EXEC end: MPC=0x110. With alu_z=0: MPC=0x010.
REQ-032 JMPC=1, NEXT=0x000, mbr=8'h60: MPC=0x060. With NEXT=0x100, JAMN=1, alu_n=1, JMPC=1, mbr=8'hFF: MPC=0x1FF.
REQ-033 MICROSEQ_STALL_EN defined, stall=1 for 3 EXEC edges with mem_ctrl=3'b010: outputs are held for 4 cycles and MPC is unchanged until the 4th edge. Undefined build: the same stimulus advances after 1 edge.
REQ-034 reset_n pulled low mid-EXEC with c_en=9'h1FF: c_en goes to 0 asynchronously; on release, cs_addr=0x000.
REQ-035 Every FETCH cycle, over a random 1000-instruction run: a_sel=4'hF, c_en=0 and mem_ctrl=0.
